// File: rtl/jts16_busarb_pkg.sv
// Shared definitions for the 68000 bus-mastership arbiter.
// Holds the arbiter state encoding, the requester limit and a helper that
// sizes requester index fields.
package jts16_busarb_pkg;

  // IDLE: nobody asked; REQ: BRn driven, waiting for a free bus;
  // OWN: a secondary master holds gnt; REL: one-tick turnaround before BGACKn rises.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2,
    ST_REL  = 2'd3
  } state_e;

  localparam int NREQ_MAX = 4;

  // Width of an index able to address n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jts16_busarb_if.sv
// Bus-mastership handshake bundle between the arbiter and its surroundings.
// Signals:
//   ASn, DTACKn, BGn  68000 address strobe, current DTACK, bus grant (to arbiter)
//   req               per-master level request (to arbiter)
//   BRn, BGACKn       bus request / grant acknowledge to the 68000 (from arbiter)
//   gnt               one-hot grant to the secondary masters (from arbiter)
//   cpu_off           high while a secondary master owns the bus (from arbiter)
// Modports: master = arbiter side, slave = CPU/requester side.
interface jts16_busarb_if #(
  parameter int NREQ = 2
);
  logic            ASn;
  logic            DTACKn;
  logic            BGn;
  logic [NREQ-1:0] req;
  logic            BRn;
  logic            BGACKn;
  logic [NREQ-1:0] gnt;
  logic            cpu_off;

  modport master (
    input  ASn, DTACKn, BGn, req,
    output BRn, BGACKn, gnt, cpu_off
  );

  modport slave (
    output ASn, DTACKn, BGn, req,
    input  BRn, BGACKn, gnt, cpu_off
  );
endinterface

// File: rtl/jts16_busarb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i     request vector
//   last_i    index of the last master that completed a grant
//   onehot_o  one-hot winner (zero when nothing requests)
//   idx_o     winner index
//   valid_o   at least one request present
// Scanning starts at last_i+1 and wraps, so the previous winner has the
// lowest priority and a lone requester always wins.
module jts16_busarb_rr_pick
  import jts16_busarb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
)(
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  // Scan requesters starting right after the last winner; first hit wins.
  always_comb begin
    int j;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    j        = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(last_i) + i) % NREQ;
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        idx_o       = IW'(j);
        onehot_o[j] = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/jts16_busarb.sv
// 68000 bus-mastership arbiter: shares the main bus between the CPU and NREQ
// secondary masters through the BR/BG/BGACK protocol.
// Ports:
//   rst        asynchronous active-high reset
//   clk        clock
//   cpu_cen_i  CPU clock enable; state only moves on enabled edges
//   bus        handshake bundle (master modport), see jts16_busarb_if
// The bus is only taken when BG is granted and no CPU cycle is running
// (ASn and DTACKn both high). A grant ends when the master drops its
// request or, with MAXHOLD != 0, after MAXHOLD enabled ticks.
module jts16_busarb
  import jts16_busarb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MAXHOLD = 0,
  parameter int CW      = 8
)(
  input  logic           rst,
  input  logic           clk,
  input  logic           cpu_cen_i,
  jts16_busarb_if.master bus
);

  localparam int              IW        = idx_width(NREQ);
  localparam logic [IW-1:0]   LAST_RST  = IW'(NREQ - 1);
  localparam logic [CW-1:0]   HOLD_LAST = CW'((MAXHOLD > 0) ? (MAXHOLD - 1) : 0);
  localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};

  state_e          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [NREQ-1:0] win_oh_q, win_oh_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            brn_q, brn_d;
  logic            bgackn_q, bgackn_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            cpu_off_q, cpu_off_d;

  logic [NREQ-1:0] pick_oh_s;
  logic [IW-1:0]   pick_idx_s;
  logic            pick_valid_s;
  logic            win_req_s;
  logic            bus_free_s;
  logic            hold_exp_s;

  jts16_busarb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i    (bus.req),
    .last_i   (last_q),
    .onehot_o (pick_oh_s),
    .idx_o    (pick_idx_s),
    .valid_o  (pick_valid_s)
  );

  assign win_req_s  = |(bus.req & win_oh_q);
  assign bus_free_s = !bus.BGn && bus.ASn && bus.DTACKn;
  assign hold_exp_s = (MAXHOLD != 0) && (cnt_q == HOLD_LAST);

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    win_oh_d  = win_oh_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    brn_d     = brn_q;
    bgackn_d  = bgackn_q;
    gnt_d     = gnt_q;
    if (cpu_cen_i) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_s) begin
            win_d    = pick_idx_s;
            win_oh_d = pick_oh_s;
            brn_d    = 1'b0;
            state_d  = ST_REQ;
          end else begin
            state_d  = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (!win_req_s) begin
            // Winner gave up before the bus arrived: re-pick without
            // touching last, or withdraw BR when nobody is left.
            if (pick_valid_s) begin
              win_d    = pick_idx_s;
              win_oh_d = pick_oh_s;
            end else begin
              brn_d    = 1'b1;
              state_d  = ST_IDLE;
            end
          end else if (bus_free_s) begin
            bgackn_d = 1'b0;
            brn_d    = 1'b1;
            gnt_d    = win_oh_q;
            cnt_d    = '0;
            state_d  = ST_OWN;
          end else begin
            state_d  = ST_REQ;
          end
        end
        ST_OWN: begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CW'(1));
          if (!win_req_s || hold_exp_s) begin
            gnt_d   = '0;
            state_d = ST_REL;
          end else begin
            state_d = ST_OWN;
          end
        end
        ST_REL: begin
          // gnt dropped one tick ago; BGACKn rises only now so the
          // departing master has a full tick to float the bus.
          bgackn_d = 1'b1;
          last_d   = win_q;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d  = ST_IDLE;
          brn_d    = 1'b1;
          bgackn_d = 1'b1;
          gnt_d    = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    cpu_off_d = ~bgackn_d;
  end

  // State, index, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      win_oh_q  <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      brn_q     <= 1'b1;
      bgackn_q  <= 1'b1;
      gnt_q     <= '0;
      cpu_off_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      win_oh_q  <= win_oh_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      brn_q     <= brn_d;
      bgackn_q  <= bgackn_d;
      gnt_q     <= gnt_d;
      cpu_off_q <= cpu_off_d;
    end
  end

  assign bus.BRn     = brn_q;
  assign bus.BGACKn  = bgackn_q;
  assign bus.gnt     = gnt_q;
  assign bus.cpu_off = cpu_off_q;

endmodule

// File: tb/tb_jts16_busarb.sv
// Directed bench for jts16_busarb: one instance with unlimited hold and one
// with MAXHOLD=16. Each tick is one enabled clock edge followed by one
// disabled edge, so outputs are also required to hold while cpu_cen=0.
module tb_jts16_busarb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_cen = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jts16_busarb_if #(.NREQ(2)) ifa ();
  jts16_busarb_if #(.NREQ(2)) ifb ();

  jts16_busarb #(.NREQ(2), .MAXHOLD(0), .CW(8)) dut_a (
    .rst       (rst),
    .clk       (clk),
    .cpu_cen_i (cpu_cen),
    .bus       (ifa)
  );

  jts16_busarb #(.NREQ(2), .MAXHOLD(16), .CW(8)) dut_b (
    .rst       (rst),
    .clk       (clk),
    .cpu_cen_i (cpu_cen),
    .bus       (ifb)
  );

  // {BRn, BGACKn, gnt[1:0], cpu_off}
  typedef struct packed {
    logic [1:0] req;
    logic       bgn;
    logic       asn;
    logic       dtackn;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [1:0] r, input logic b, input logic a,
                              input logic d, input logic [4:0] e);
    vec_t v;
    v.req = r; v.bgn = b; v.asn = a; v.dtackn = d; v.exp = e;
    return v;
  endfunction

  function automatic logic [4:0] obs_a();
    return {ifa.BRn, ifa.BGACKn, ifa.gnt, ifa.cpu_off};
  endfunction

  function automatic logic [4:0] obs_b();
    return {ifb.BRn, ifb.BGACKn, ifb.gnt, ifb.cpu_off};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Structural rules that must hold after every tick.
  task automatic inv(input string nm, input logic brn, input logic bgackn,
                     input logic [1:0] gnt, input logic off);
    logic ok;
    ok = $onehot0(gnt) && !(brn == 1'b0 && bgackn == 1'b0)
         && !(gnt != 2'b00 && bgackn != 1'b0) && (off == ~bgackn);
    chk(nm, {7'd0, ok}, 8'd1);
  endtask

  task automatic tick();
    cpu_cen = 1'b1;
    @(posedge clk); #1;
    cpu_cen = 1'b0;
    @(posedge clk); #1;
    inv("inv_a", ifa.BRn, ifa.BGACKn, ifa.gnt, ifa.cpu_off);
    inv("inv_b", ifb.BRn, ifb.BGACKn, ifb.gnt, ifb.cpu_off);
  endtask

  task automatic drive_a(input logic [1:0] r, input logic b, input logic a, input logic d);
    ifa.req = r; ifa.BGn = b; ifa.ASn = a; ifa.DTACKn = d;
  endtask

  initial begin
    logic [1:0] w_oh;
    logic [1:0] other_oh;

    drive_a(2'b00, 1'b1, 1'b1, 1'b1);
    ifb.req = 2'b00; ifb.BGn = 1'b1; ifb.ASn = 1'b1; ifb.DTACKn = 1'b1;

    // Single master, cycle guard, abort and last-pointer behaviour.
    vecs[0]  = mk(2'b01, 1'b1, 1'b1, 1'b1, 5'b01000);
    vecs[1]  = mk(2'b01, 1'b1, 1'b1, 1'b1, 5'b01000);
    vecs[2]  = mk(2'b01, 1'b1, 1'b1, 1'b1, 5'b01000);
    vecs[3]  = mk(2'b01, 1'b0, 1'b1, 1'b1, 5'b10011);
    vecs[4]  = mk(2'b01, 1'b1, 1'b1, 1'b1, 5'b10011);
    vecs[5]  = mk(2'b00, 1'b1, 1'b1, 1'b1, 5'b10001);
    vecs[6]  = mk(2'b00, 1'b1, 1'b1, 1'b1, 5'b11000);
    vecs[7]  = mk(2'b10, 1'b1, 1'b1, 1'b1, 5'b01000);
    vecs[8]  = mk(2'b10, 1'b0, 1'b0, 1'b1, 5'b01000);
    vecs[9]  = mk(2'b10, 1'b0, 1'b0, 1'b1, 5'b01000);
    vecs[10] = mk(2'b10, 1'b0, 1'b0, 1'b1, 5'b01000);
    vecs[11] = mk(2'b10, 1'b0, 1'b0, 1'b1, 5'b01000);
    vecs[12] = mk(2'b10, 1'b0, 1'b0, 1'b1, 5'b01000);
    vecs[13] = mk(2'b10, 1'b0, 1'b1, 1'b0, 5'b01000);
    vecs[14] = mk(2'b10, 1'b0, 1'b1, 1'b1, 5'b10101);
    vecs[15] = mk(2'b00, 1'b1, 1'b1, 1'b1, 5'b10001);
    vecs[16] = mk(2'b00, 1'b1, 1'b1, 1'b1, 5'b11000);
    vecs[17] = mk(2'b01, 1'b1, 1'b1, 1'b1, 5'b01000);
    vecs[18] = mk(2'b00, 1'b1, 1'b1, 1'b1, 5'b11000);
    vecs[19] = mk(2'b11, 1'b1, 1'b1, 1'b1, 5'b01000);
    vecs[20] = mk(2'b11, 1'b0, 1'b1, 1'b1, 5'b10011);

    // Reset values, while reset is held and after release.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", {3'd0, obs_a()}, {3'd0, 5'b11000});
    chk("reset_b", {3'd0, obs_b()}, {3'd0, 5'b11000});
    rst = 1'b0;
    tick();
    chk("idle_a", {3'd0, obs_a()}, {3'd0, 5'b11000});

    for (int i = 0; i < 21; i++) begin
      drive_a(vecs[i].req, vecs[i].bgn, vecs[i].asn, vecs[i].dtackn);
      tick();
      chk($sformatf("vec[%0d]", i), {3'd0, obs_a()}, {3'd0, vecs[i].exp});
    end

    // Round-robin: both request, holder drops for one tick and returns.
    w_oh = 2'b01;
    for (int r = 0; r < 4; r++) begin
      other_oh = ~w_oh;
      for (int k = 1; k <= 9; k++) begin
        drive_a(2'b11, 1'b0, 1'b1, 1'b1);
        tick();
        chk($sformatf("rr%0d_hold%0d", r, k), {6'd0, ifa.gnt}, {6'd0, w_oh});
      end
      drive_a(other_oh, 1'b0, 1'b1, 1'b1);
      tick();
      chk($sformatf("rr%0d_drop", r), {3'd0, obs_a()}, {3'd0, 5'b10001});
      drive_a(2'b11, 1'b0, 1'b1, 1'b1);
      tick();
      chk($sformatf("rr%0d_rel", r), {3'd0, obs_a()}, {3'd0, 5'b11000});
      tick();
      chk($sformatf("rr%0d_br", r), {3'd0, obs_a()}, {3'd0, 5'b01000});
      tick();
      chk($sformatf("rr%0d_gnt", r), {3'd0, obs_a()}, {3'd0, 1'b1, 1'b0, other_oh, 1'b1});
      w_oh = other_oh;
    end
    drive_a(2'b00, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("rr_end", {3'd0, obs_a()}, {3'd0, 5'b11000});

    // Asynchronous reset while master 1 owns the bus.
    drive_a(2'b10, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    chk("pre_rst_gnt", {3'd0, obs_a()}, {3'd0, 5'b10101});
    #1 rst = 1'b1;
    #1 chk("rst_async", {3'd0, obs_a()}, {3'd0, 5'b11000});
    #1 rst = 1'b0;
    drive_a(2'b10, 1'b1, 1'b1, 1'b1);
    tick();
    chk("post_rst_br", {3'd0, obs_a()}, {3'd0, 5'b01000});
    drive_a(2'b10, 1'b0, 1'b1, 1'b1);
    tick();
    chk("post_rst_gnt", {3'd0, obs_a()}, {3'd0, 5'b10101});
    drive_a(2'b00, 1'b1, 1'b1, 1'b1);
    tick();
    tick();

    // Timeout: MAXHOLD=16 with the request held throughout.
    ifb.req = 2'b01; ifb.BGn = 1'b0; ifb.ASn = 1'b1; ifb.DTACKn = 1'b1;
    tick();
    chk("to_br", {3'd0, obs_b()}, {3'd0, 5'b01000});
    tick();
    chk("to_gnt0", {3'd0, obs_b()}, {3'd0, 5'b10011});
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("to_gnt%0d", k), {3'd0, obs_b()}, {3'd0, 5'b10011});
    end
    tick();
    chk("to_drop", {3'd0, obs_b()}, {3'd0, 5'b10001});
    tick();
    chk("to_rel", {3'd0, obs_b()}, {3'd0, 5'b11000});
    tick();
    chk("to_rebr", {3'd0, obs_b()}, {3'd0, 5'b01000});
    tick();
    chk("to_regnt", {3'd0, obs_b()}, {3'd0, 5'b10011});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
